riscv_test_mem: RTL and testbench
=================================

// Module: riscv_test_mem
// PURPOSE
//  Parametrised instruction/data memory model plus test-completion monitor for core-level simulation.
//  Serves an instruction fetch port and a data port with byte strobes from one shared word array.
//  Read latency is configurable. A small FSM declares pass/fail/timeout for riscv-tests style programs.
//  Sits beside the core in the testbench top; the bench drives only clock, reset and the preload file.
// PARAMETERS
//  ADDR_W      12             word-address bits; depth = 2**ADDR_W words of 32 bits
//  RD_LAT      1              read latency in cycles for both ports, legal 1..4
//  INIT_FILE   ""             hex file loaded with $readmemh at time 0; empty = no preload
//  PASS_PC     32'h00000044   fetch address that signals pass
//  TOHOST_ADDR 32'h00001000   byte address of the tohost word
//  TIMEOUT     2500           cycles after reset release before timeout is declared
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  pc_in        in   32  instruction fetch byte address
//  inst_out     out  32  fetched instruction, RD_LAT cycles after pc_in
//  data_re      in   1   data read request
//  data_raddr   in   32  data read byte address
//  data_rdata   out  32  read data, RD_LAT cycles after request
//  data_we      in   1   data write enable
//  data_wstrb   in   4   byte strobes for the write; bit i = byte i
//  data_waddr   in   32  data write byte address
//  data_wdata   in   32  write data
//  test_done    out  1   sticky: test has finished
//  test_pass    out  1   valid when test_done; 1 = pass
//  test_timeout out  1   valid when test_done; 1 = finished by timeout
//  fail_code    out  31  tohost value >> 1 on fail (riscv-tests testnum), else 0
//  cycle_cnt    out  32  cycles since reset release, saturating
// BEHAVIOUR
//  Indexing: word index = addr[ADDR_W+1:2]. Upper bits and addr[1:0] are ignored, so addresses wrap modulo depth.
//  Reset (rst_n=0): inst_out, data_rdata, test_*, fail_code and cycle_cnt go to 0 immediately. Read pipelines are flushed; FSM goes to RUN.
//  Reset never clears array contents. Reset mid-run discards in-flight reads; nothing issued before reset ever emerges.
//  Read pipeline: RD_LAT-stage shift register per port carrying {valid, word}. The array is read in the issue cycle.
//  Fetch is always valid once out of reset. data_rdata = 0 when data_re was 0 at issue.
//  Write: at the rising edge with data_we=1, only bytes with data_wstrb[i]=1 update. data_wstrb=0 is a no-op.
//  Read/write collision, same word, same edge: the read returns the old contents (read-first). The next read sees the new data.
//  Fetch and data read of the same word in one cycle are both serviced; there are no stalls.
//  cycle_cnt increments every cycle out of reset and saturates at 2^32-1. It keeps counting in DONE.
//  FSM: RUN -> DONE. DONE is sticky until reset. Memory keeps serving in DONE.
//   tohost event: data_we=1, data_wstrb!=0 and data_waddr[31:2]==TOHOST_ADDR[31:2].
//    wdata==1 -> pass. Any other wdata -> fail, fail_code=wdata[31:1].
//   pc_in==PASS_PC -> pass.
//   cycle_cnt==TIMEOUT-1 -> test_timeout=1, test_pass=0.
//   Priority within one cycle: tohost > PASS_PC > timeout.
//  The tohost write also updates the array like any other write.
//  Status outputs are registered and assert the cycle after the triggering edge.
// TESTING
//  RD_LAT=1; preload mem[5]=32'hDEADBEEF; pc_in=0x14 -> inst_out=DEADBEEF one cycle later.
//  RD_LAT=3; back-to-back data reads of words 0,1,2 -> data_rdata returns them in order 3 cycles after each issue. Idle cycles return 0.
//  Word 0x20 = 0x11223344; write wstrb=4'b0101, wdata=0xAABBCCDD -> read returns 0x11BB33DD.
//  Read and write of word 7 in the same cycle -> read returns the old value; the following read returns the new value.
//  Write tohost=0x7 -> test_done=1, test_pass=0, fail_code=3. A later pc_in=PASS_PC leaves the result unchanged.
//  No events, TIMEOUT=50 -> test_done=1 and test_timeout=1 after 50 cycles. Assert rst_n=0 mid-run -> all status clears and the array is retained.

Source files
------------

// File: rtl/riscv_test_mem.sv
// riscv_test_mem: word-addressed instruction/data memory model with a test-completion monitor.
//
// One shared array of 2**ADDR_W 32-bit words serves a fetch port and a data port (read +
// byte-strobed write). Both read ports are RD_LAT-stage pipelines; the array is sampled in the
// issue cycle and the result appears RD_LAT cycles later. Writes are read-first with respect to
// a read of the same word on the same edge.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   pc_in / inst_out                fetch byte address / fetched word
//   data_re, data_raddr / data_rdata   data read request, byte address / read word (0 if no read)
//   data_we, data_wstrb, data_waddr, data_wdata   byte-strobed data write
//   test_done, test_pass, test_timeout, fail_code  sticky test result
//   cycle_cnt                       saturating cycle count since reset release
module riscv_test_mem #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned RD_LAT      = 1,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] PASS_PC     = 32'h0000_0044,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int unsigned TIMEOUT     = 2500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic [31:0] inst_out,
  input  logic        data_re,
  input  logic [31:0] data_raddr,
  output logic [31:0] data_rdata,
  input  logic        data_we,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_waddr,
  input  logic [31:0] data_wdata,
  output logic        test_done,
  output logic        test_pass,
  output logic        test_timeout,
  output logic [30:0] fail_code,
  output logic [31:0] cycle_cnt
);

  localparam int unsigned Depth       = 2 ** ADDR_W;
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StDone} state_e;

  logic [31:0] mem_q [Depth];

  logic [ADDR_W-1:0] fetch_idx, rd_idx, wr_idx;
  assign fetch_idx = pc_in[ADDR_W+1:2];
  assign rd_idx    = data_raddr[ADDR_W+1:2];
  assign wr_idx    = data_waddr[ADDR_W+1:2];

  // Upper address bits and byte offsets are intentionally ignored (addresses wrap).
  logic unused_addr;
  assign unused_addr = ^{data_raddr, data_waddr[1:0]};

  // Array contents are not reset.
  always_ff @(posedge clk) begin
    if (data_we) begin
      for (int b = 0; b < 4; b++) begin
        if (data_wstrb[b]) mem_q[wr_idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  // Read pipelines: stage 0 captures the array in the issue cycle.
  logic [RD_LAT-1:0] inst_vld_q, inst_vld_d, rd_vld_q, rd_vld_d;
  logic [31:0]       inst_word_q [RD_LAT];
  logic [31:0]       inst_word_d [RD_LAT];
  logic [31:0]       rd_word_q   [RD_LAT];
  logic [31:0]       rd_word_d   [RD_LAT];

  always_comb begin
    inst_vld_d     = inst_vld_q;
    rd_vld_d       = rd_vld_q;
    inst_word_d    = inst_word_q;
    rd_word_d      = rd_word_q;
    inst_vld_d[0]  = 1'b1;
    inst_word_d[0] = mem_q[fetch_idx];
    rd_vld_d[0]    = data_re;
    rd_word_d[0]   = data_re ? mem_q[rd_idx] : 32'h0;
    for (int i = 1; i < RD_LAT; i++) begin
      inst_vld_d[i]  = inst_vld_q[i-1];
      inst_word_d[i] = inst_word_q[i-1];
      rd_vld_d[i]    = rd_vld_q[i-1];
      rd_word_d[i]   = rd_word_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_vld_q  <= '0;
      rd_vld_q    <= '0;
      inst_word_q <= '{default: '0};
      rd_word_q   <= '{default: '0};
    end else begin
      inst_vld_q  <= inst_vld_d;
      rd_vld_q    <= rd_vld_d;
      inst_word_q <= inst_word_d;
      rd_word_q   <= rd_word_d;
    end
  end

  assign inst_out   = inst_vld_q[RD_LAT-1] ? inst_word_q[RD_LAT-1] : 32'h0;
  assign data_rdata = rd_vld_q[RD_LAT-1]   ? rd_word_q[RD_LAT-1]   : 32'h0;

  // Completion monitor.
  state_e      state_q, state_d;
  logic        pass_q, pass_d, timeout_q, timeout_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        tohost_hit, pass_hit, timeout_hit;

  assign tohost_hit  = data_we && (|data_wstrb) && (data_waddr[31:2] == TOHOST_ADDR[31:2]);
  assign pass_hit    = (pc_in == PASS_PC);
  assign timeout_hit = (cycle_cnt_q == TimeoutLast);

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_code_d = fail_code_q;
    cycle_cnt_d = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    case (state_q)
      StRun: begin
        // Priority: tohost write, then pass PC, then timeout.
        if (tohost_hit) begin
          state_d     = StDone;
          pass_d      = (data_wdata == 32'd1);
          fail_code_d = (data_wdata == 32'd1) ? 31'd0 : data_wdata[31:1];
        end else if (pass_hit) begin
          state_d = StDone;
          pass_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StDone;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_code_q <= fail_code_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign test_done    = (state_q == StDone);
  assign test_pass    = pass_q;
  assign test_timeout = timeout_q;
  assign fail_code    = fail_code_q;
  assign cycle_cnt    = cycle_cnt_q;

endmodule

// File: tb/tb_riscv_test_mem.sv
// Bench for riscv_test_mem: two instances (RD_LAT=3 and RD_LAT=1 with TIMEOUT=50) share stimulus.
// A reference model (word array + history of issued reads) predicts both read ports.
module tb_riscv_test_mem;

  localparam int AW = 6;

  logic        clk, rst_n;
  logic [31:0] pc_in, data_raddr, data_waddr, data_wdata;
  logic        data_re, data_we;
  logic [3:0]  data_wstrb;

  logic [31:0] a_inst, a_data, a_cnt, b_inst, b_data, b_cnt;
  logic        a_done, a_pass, a_tmo, b_done, b_pass, b_tmo;
  logic [30:0] a_fail, b_fail;

  riscv_test_mem #(.ADDR_W(AW), .RD_LAT(3)) u_a (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .inst_out(a_inst),
    .data_re(data_re), .data_raddr(data_raddr), .data_rdata(a_data),
    .data_we(data_we), .data_wstrb(data_wstrb), .data_waddr(data_waddr),
    .data_wdata(data_wdata), .test_done(a_done), .test_pass(a_pass),
    .test_timeout(a_tmo), .fail_code(a_fail), .cycle_cnt(a_cnt)
  );

  riscv_test_mem #(.ADDR_W(AW), .RD_LAT(1), .TIMEOUT(50)) u_b (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .inst_out(b_inst),
    .data_re(data_re), .data_raddr(data_raddr), .data_rdata(b_data),
    .data_we(data_we), .data_wstrb(data_wstrb), .data_waddr(data_waddr),
    .data_wdata(data_wdata), .test_done(b_done), .test_pass(b_pass),
    .test_timeout(b_tmo), .fail_code(b_fail), .cycle_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] mdl_mem [2**AW];
  logic [31:0] hist_i[$];
  logic [31:0] hist_d[$];
  int          nsince = 0;
  logic [31:0] mdl_cnt = 0;
  bit          chk_on = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] init;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] pat(int i);
    return (i == 5) ? 32'hDEAD_BEEF : {16'hC0DE, 8'(i), 8'(255 - i)};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_i(int lat);
    return (nsince >= lat) ? hist_i[hist_i.size() - lat] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_d(int lat);
    return (nsince >= lat) ? hist_d[hist_d.size() - lat] : 32'h0;
  endfunction

  // One clock: model samples the current inputs, then outputs are checked 1 time unit later.
  task automatic step();
    if (rst_n) begin
      hist_i.push_back(mdl_mem[pc_in[AW+1:2]]);
      hist_d.push_back(data_re ? mdl_mem[data_raddr[AW+1:2]] : 32'h0);
      if (hist_i.size() > 4) begin
        void'(hist_i.pop_front());
        void'(hist_d.pop_front());
      end
      nsince++;
      if (data_we)
        for (int b = 0; b < 4; b++)
          if (data_wstrb[b]) mdl_mem[data_waddr[AW+1:2]][8*b +: 8] = data_wdata[8*b +: 8];
      if (mdl_cnt != 32'hFFFF_FFFF) mdl_cnt++;
    end
    @(posedge clk);
    #1;
    if (chk_on) begin
      check("inst_lat3", a_inst, exp_i(3));
      check("inst_lat1", b_inst, exp_i(1));
      check("rdata_lat3", a_data, exp_d(3));
      check("rdata_lat1", b_data, exp_d(1));
    end
    check("cycle_cnt_a", a_cnt, mdl_cnt);
    check("cycle_cnt_b", b_cnt, mdl_cnt);
  endtask

  task automatic chk_status(string name, logic done, logic pass, logic tmo, logic [30:0] fc);
    check({name, "_done_a"}, {31'd0, a_done}, {31'd0, done});
    check({name, "_pass_a"}, {31'd0, a_pass}, {31'd0, pass});
    check({name, "_tmo_a"}, {31'd0, a_tmo}, {31'd0, tmo});
    check({name, "_fcode_a"}, {1'b0, a_fail}, {1'b0, fc});
    check({name, "_done_b"}, {31'd0, b_done}, {31'd0, done});
    check({name, "_pass_b"}, {31'd0, b_pass}, {31'd0, pass});
    check({name, "_tmo_b"}, {31'd0, b_tmo}, {31'd0, tmo});
    check({name, "_fcode_b"}, {1'b0, b_fail}, {1'b0, fc});
  endtask

  // Reset is asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst_n   = 1'b0;
    data_we = 1'b0;
    data_re = 1'b0;
    #2;
    check("rst_inst_a", a_inst, 32'h0);
    check("rst_data_a", a_data, 32'h0);
    check("rst_inst_b", b_inst, 32'h0);
    check("rst_data_b", b_data, 32'h0);
    check("rst_cnt", a_cnt, 32'h0);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 31'd0);
    hist_i.delete();
    hist_d.delete();
    nsince  = 0;
    mdl_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wr(logic [31:0] addr, logic [3:0] strb, logic [31:0] wd);
    data_we = 1'b1; data_waddr = addr; data_wstrb = strb; data_wdata = wd;
    step();
    data_we = 1'b0;
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{32'h80, 32'h1122_3344, 4'b0101, 32'hAABB_CCDD, 32'h11BB_33DD};
    vecs[1] = '{32'h84, 32'h1122_3344, 4'b0000, 32'hAABB_CCDD, 32'h1122_3344};
    vecs[2] = '{32'h88, 32'h1122_3344, 4'b1111, 32'hAABB_CCDD, 32'hAABB_CCDD};
    vecs[3] = '{32'h8C, 32'h1122_3344, 4'b1000, 32'hAABB_CCDD, 32'hAA22_3344};
    vecs[4] = '{32'h190, 32'h0000_0000, 4'b0010, 32'h1234_5678, 32'h0000_5600};
    for (int i = 0; i < 2**AW; i++) mdl_mem[i] = 32'h0;

    pc_in = 0; data_re = 0; data_raddr = 0; data_we = 0; data_wstrb = 0;
    data_waddr = 0; data_wdata = 0;
    do_reset();

    // Fill the array; no events occur, so only the TIMEOUT=50 instance finishes.
    for (int k = 1; k <= 2**AW; k++) begin
      wr(32'((k - 1) * 4), 4'hF, pat(k - 1));
      if (k == 49) check("tmo_not_yet", {31'd0, b_done}, 32'd0);
      if (k == 50) begin
        check("tmo_done", {31'd0, b_done}, 32'd1);
        check("tmo_flag", {31'd0, b_tmo}, 32'd1);
        check("tmo_pass", {31'd0, b_pass}, 32'd0);
      end
    end
    check("long_to_not_done", {31'd0, a_done}, 32'd0);

    // Mid-run reset: status clears, array retained.
    do_reset();
    chk_on = 1;

    pc_in = 32'h14;
    step();
    check("preload_lat1", b_inst, 32'hDEAD_BEEF);
    step();
    step();
    check("preload_lat3", a_inst, 32'hDEAD_BEEF);
    pc_in = 0;

    // Back-to-back reads with RD_LAT=3.
    for (int k = 0; k < 6; k++) begin
      data_re    = (k < 3);
      data_raddr = 32'(k * 4);
      step();
      if (k == 0) check("b2b_lat1_first", b_data, pat(0));
      if (k == 1) check("b2b_idle0", a_data, 32'h0);
      if (k >= 2 && k <= 4) check("b2b_order", a_data, pat(k - 2));
      if (k == 5) check("b2b_idle_after", a_data, 32'h0);
    end

    // Read/write collision on word 7: read-first.
    data_re = 1; data_raddr = 32'h1C;
    wr(32'h1C, 4'hF, 32'h7777_7777);
    check("collide_old", b_data, pat(7));
    step();
    check("collide_new", b_data, 32'h7777_7777);
    data_re = 0;

    // Byte-strobe vectors.
    foreach (vecs[v]) begin
      wr(vecs[v].addr, 4'hF, vecs[v].init);
      wr(vecs[v].addr, vecs[v].wstrb, vecs[v].wdata);
      data_re = 1; data_raddr = vecs[v].addr;
      step();
      data_re = 0;
      check("strobe_lat1", b_data, vecs[v].exp);
      step();
      step();
      check("strobe_lat3", a_data, vecs[v].exp);
    end

    // Random traffic below the tohost address; PASS_PC avoided.
    for (int n = 0; n < 300; n++) begin
      pc_in = $urandom & 32'hFFF;
      if (pc_in == 32'h44) pc_in = 32'h48;
      data_re    = 1'($urandom_range(0, 1));
      data_raddr = $urandom & 32'hFFF;
      data_we    = 1'($urandom_range(0, 1));
      data_waddr = $urandom & 32'hFFF;
      data_wstrb = 4'($urandom);
      data_wdata = $urandom;
      step();
    end
    data_we = 0; data_re = 0; pc_in = 0;
    check("rand_no_event", {31'd0, a_done}, 32'd0);

    // Fail via tohost; later PASS_PC does not change the result.
    do_reset();
    wr(32'h1000, 4'hF, 32'h7);
    chk_status("tohost_fail", 1'b1, 1'b0, 1'b0, 31'd3);
    pc_in = 32'h44;
    step();
    chk_status("fail_sticky", 1'b1, 1'b0, 1'b0, 31'd3);
    pc_in = 0;
    data_re = 1; data_raddr = 32'h0;
    step();
    data_re = 0;

    // Zero strobes is not a tohost event; PASS_PC then passes.
    do_reset();
    wr(32'h1000, 4'h0, 32'h1);
    chk_status("tohost_nostrb", 1'b0, 1'b0, 1'b0, 31'd0);
    pc_in = 32'h44;
    step();
    chk_status("pass_pc", 1'b1, 1'b1, 1'b0, 31'd0);
    pc_in = 0;

    // Same cycle tohost and PASS_PC: tohost wins.
    do_reset();
    pc_in = 32'h44;
    wr(32'h1003, 4'b0001, 32'h5);
    chk_status("priority", 1'b1, 1'b0, 1'b0, 31'd2);
    pc_in = 0;

    // tohost == 1 passes.
    do_reset();
    wr(32'h1000, 4'hF, 32'h1);
    chk_status("tohost_pass", 1'b1, 1'b1, 1'b0, 31'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
